// File: rtl/itof.sv
// Three-stage elastic int32 -> float32 converter, round to nearest even.
// Stage 1 takes the magnitude, stage 2 normalises, stage 3 rounds and packs.
module itof #(
  parameter bit SIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] input_a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] output_a
);

  logic        s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic        s1_load, s2_load, s3_load;

  logic        s1_sign_reg, s1_zero_reg;
  logic [31:0] s1_mag_reg;
  logic        s2_sign_reg, s2_zero_reg;
  logic [30:0] s2_norm_reg;
  logic [7:0]  s2_exp_reg;
  logic [31:0] s3_result_reg;

  logic        s1_sign_next;
  logic [31:0] s1_mag_next;
  logic [4:0]  lz;
  logic [30:0] s2_norm_next;
  logic [7:0]  s2_exp_next;
  logic        round_up;
  logic [30:0] rounded;
  logic [31:0] s3_result_next;

  // A stage loads when it is empty or its contents move on this cycle.
  assign s3_load  = !s3_valid_reg | out_ready;
  assign s2_load  = !s2_valid_reg | s3_load;
  assign s1_load  = !s1_valid_reg | s2_load;
  assign in_ready = rstn & s1_load;

  assign out_valid = s3_valid_reg;
  assign output_a  = s3_result_reg;

  assign s1_sign_next = SIGNED & input_a[31];
  assign s1_mag_next  = s1_sign_next ? (~input_a + 32'd1) : input_a;

  // Highest set bit wins; a zero magnitude leaves lz at 0 and is masked later.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (s1_mag_reg[i]) lz = 5'(31 - i);
    end
  end

  // Bit 31 of the normalised value is the implicit one and is not stored.
  assign s2_norm_next = 31'(s1_mag_reg << lz);
  assign s2_exp_next  = 8'd158 - {3'b000, lz};

  assign round_up = s2_norm_reg[7] & ((|s2_norm_reg[6:0]) | s2_norm_reg[8]);
  // A mantissa carry-out ripples straight into the exponent field.
  assign rounded  = {s2_exp_reg, s2_norm_reg[30:8]} + {30'd0, round_up};
  assign s3_result_next = s2_zero_reg ? 32'd0 : {s2_sign_reg, rounded};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s1_sign_reg   <= 1'b0;
      s1_zero_reg   <= 1'b0;
      s1_mag_reg    <= 32'd0;
      s2_sign_reg   <= 1'b0;
      s2_zero_reg   <= 1'b0;
      s2_norm_reg   <= 31'd0;
      s2_exp_reg    <= 8'd0;
      s3_result_reg <= 32'd0;
    end else begin
      if (s1_load) s1_valid_reg <= in_valid;
      if (s2_load) s2_valid_reg <= s1_valid_reg;
      if (s3_load) s3_valid_reg <= s2_valid_reg;

      if (s1_load && in_valid) begin
        s1_sign_reg <= s1_sign_next;
        s1_zero_reg <= (s1_mag_next == 32'd0);
        s1_mag_reg  <= s1_mag_next;
      end
      if (s2_load && s1_valid_reg) begin
        s2_sign_reg <= s1_sign_reg;
        s2_zero_reg <= s1_zero_reg;
        s2_norm_reg <= s2_norm_next;
        s2_exp_reg  <= s2_exp_next;
      end
      if (s3_load && s2_valid_reg) begin
        s3_result_reg <= s3_result_next;
      end
    end
  end

endmodule

// File: doc/itof.md
Name: itof

Overview:
- Pipelined int32-to-float32 converter for the FPU; the companion to the float-to-integral rounding units.
- Converts a 32-bit integer (signed or unsigned, per parameter) to IEEE-754 single precision, rounding to nearest, ties to even.
- 3-stage elastic pipeline with valid/ready handshake on both sides, so it can sit between the ALU writeback and the FPU issue queue.

Parameters:
SIGNED, 1, 1: input is two's complement; 0: input is unsigned.

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  synchronous active-low reset
in_valid  input  1  input_a holds a valid operand
in_ready  output  1  converter accepts input this cycle
input_a  input  32  integer operand
out_valid  output  1  output_a holds a valid result
out_ready  input  1  consumer accepts result this cycle
output_a  output  32  float32 result {sign, exp[7:0], mant[22:0]}

Behaviour:
- Reset (rstn=0 at a clk edge): all stage valid bits clear, all data registers 0, out_valid=0, output_a=0. in_ready=0 while rstn=0. In-flight operands are discarded; no partial result ever appears after reset.
- Handshake:
  - Transfer in when in_valid&in_ready; transfer out when out_valid&out_ready.
  - Each stage N loads when stage N is empty or stage N+1 loads (stage 3 "loads" on out_ready).
  - in_ready = !s1_valid | s1_advance; combinational, no dependence on in_valid.
  - output_a/out_valid held stable while out_valid&!out_ready.
  - Throughput 1/cycle; latency 3 cycles from input acceptance to out_valid with out_ready held 1.
  - No bubbles are inserted and no operands are dropped or duplicated under any stall pattern.
- Stage 1:
  - sign = SIGNED & input_a[31].
  - mag = sign ? (~input_a+1) : input_a, 32-bit unsigned. -2^31 gives mag=0x80000000.
  - zero flag = (mag==0).
- Stage 2:
  - lz = leading-zero count of mag (0..31).
  - norm = mag << lz, so norm[31]=1 unless zero.
  - e = 158 - lz (8-bit; = 127+31-lz).
- Stage 3:
  - m = norm[30:8], guard g = norm[7], sticky s = |norm[6:0].
  - Round up iff g & (s | m[0]).
  - If m=all ones and round up: mant=0, exp=e+1. Otherwise mant=m+roundup, exp=e.
  - zero flag forces output {1'b0,31'b0}; -0 is never produced.
- Inputs with |x| < 2^24 are exact.
- No overflow is possible: maximum exp = 159 (unsigned 2^32).
- No exception flags.

Test Plan:
- Basic values, out_ready=1, back-to-back (SIGNED=1): 0→0x00000000, 1→0x3F800000, 0xFFFFFFFF(−1)→0xBF800000, 0x80000000→0xCF000000, 0x7FFFFFFF→0x4F000000. Each appears exactly 3 cycles after acceptance, one per cycle.
- Rounding: 0x01000001→0x4B800000 (tie, even down); 0x01000003→0x4B800002 (tie, up); 0x01000002→0x4B800001 (exact); 0x02000006→0x4C000002 (tie with odd m[0]=1, rounds up to even).
- Carry into exponent: 0x00FFFFFF→0x4B7FFFFF (exact); 0x7FFFFFC0→0x4F000000 (mantissa overflow, exp 157→158).
- Backpressure: stream 10 operands with out_ready = 1,0,0,1,0,1… pattern:
  - results match in order, none lost or duplicated;
  - output_a stable while stalled;
  - in_ready drops once all 3 stages are full, and recovers the cycle out_ready returns.
- Reset mid-operation: fill pipeline, pulse rstn=0 one cycle:
  - next cycle out_valid=0, output_a=0;
  - an operand accepted after reset emerges 3 cycles later, with no stale results emitted.
- SIGNED=0 instance: 0xFFFFFFFF→0x4F800000, 0x80000000→0x4F000000, 5→0x40A00000.
